// File: rtl/masked_stim_sequencer.sv
// masked_stim_sequencer
//   Accepts unmasked secret vectors over a valid/ready handshake, masks each
//   secret bit with a fresh random bit, launches the resulting bus into a
//   gate-level DUT with a programmable per-bit cycle skew, waits a fixed DUT
//   latency and then returns the captured DUT output with the applied vector.
//
//   Optional build macro: FIXED_RAND_EN
//     defined   : adds input rand_fixed; randomness comes from that port and
//                 the internal LFSR is removed (deterministic reference runs).
//     undefined : randomness comes from the internal Galois LFSR.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready request handshake (s_ready high only while idle)
//   s_secret        unmasked secret bits
//   s_skew          per-bit launch skew, field j = [j*SKEW_W +: SKEW_W]
//   rand_fixed      fixed random bits (FIXED_RAND_EN builds only)
//   dut_in          registered DUT input bus {masked, rand}
//   dut_out         DUT output
//   m_valid/m_ready capture handshake
//   m_out           captured dut_out
//   m_applied       final dut_in vector of the transaction
module masked_stim_sequencer #(
  parameter int                N_SECRETS   = 2,
  parameter int                N_RAND      = 2,
  parameter int                OUT_SIZE    = 1,
  parameter int                DUT_LATENCY = 1,
  parameter int                SKEW_MAX    = 3,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(1),
  localparam int               IN_SIZE     = N_SECRETS + N_RAND,
  localparam int               SKEW_W      = (SKEW_MAX < 1) ? 1 : $clog2(SKEW_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [N_SECRETS-1:0]      s_secret,
  input  logic [IN_SIZE*SKEW_W-1:0] s_skew,
`ifdef FIXED_RAND_EN
  input  logic [N_RAND-1:0]         rand_fixed,
`endif
  output logic [IN_SIZE-1:0]        dut_in,
  input  logic [OUT_SIZE-1:0]       dut_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_SIZE-1:0]       m_out,
  output logic [IN_SIZE-1:0]        m_applied
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  // One counter serves both the launch window and the latency wait.
  localparam int CNT_MAX = (SKEW_MAX > DUT_LATENCY) ? SKEW_MAX : DUT_LATENCY;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  function automatic logic [SKEW_W-1:0] clamp_skew(input logic [SKEW_W-1:0] s);
    if (int'(s) > SKEW_MAX) return SKEW_W'(SKEW_MAX);
    return s;
  endfunction

`ifndef FIXED_RAND_EN
  localparam logic [LFSR_W-1:0] POLY     = LFSR_W'(16'hB400);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [LFSR_W-1:0] SEED_FIX = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
`endif

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IN_SIZE-1:0]        target_q, target_d;
  logic [IN_SIZE*SKEW_W-1:0] skew_q, skew_d;
  logic [IN_SIZE-1:0]        dut_in_q, dut_in_d;
  logic                      m_valid_q, m_valid_d;
  logic [OUT_SIZE-1:0]       m_out_q, m_out_d;
  logic [IN_SIZE-1:0]        m_applied_q, m_applied_d;

  logic [N_RAND-1:0]         rand_w;
  logic [IN_SIZE-1:0]        vec_w;
  logic [IN_SIZE*SKEW_W-1:0] skew_clamp_w;

  // Masked vector and clamped skews as they would be latched this cycle.
  always_comb begin
    vec_w        = '0;
    skew_clamp_w = '0;
`ifdef FIXED_RAND_EN
    rand_w = rand_fixed;
`else
    rand_w = lfsr_q[N_RAND-1:0];
`endif
    vec_w[N_RAND-1:0] = rand_w;
    for (int i = 0; i < N_SECRETS; i++)
      vec_w[N_RAND+i] = s_secret[i] ^ rand_w[i % N_RAND];
    for (int j = 0; j < IN_SIZE; j++)
      skew_clamp_w[j*SKEW_W +: SKEW_W] = clamp_skew(s_skew[j*SKEW_W +: SKEW_W]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    skew_d      = skew_q;
    dut_in_d    = dut_in_q;
    m_valid_d   = m_valid_q;
    m_out_d     = m_out_q;
    m_applied_d = m_applied_q;
`ifndef FIXED_RAND_EN
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          target_d = vec_w;
          skew_d   = skew_clamp_w;
          cnt_d    = '0;
`ifndef FIXED_RAND_EN
          lfsr_d   = lfsr_step(lfsr_q);
`endif
          // Zero-skew bits launch on the accept edge itself.
          for (int j = 0; j < IN_SIZE; j++)
            if (skew_clamp_w[j*SKEW_W +: SKEW_W] == '0) dut_in_d[j] = vec_w[j];
          state_d = (SKEW_MAX == 0) ? WAIT : LAUNCH;
        end
      end
      LAUNCH: begin
        // cnt_q+1 is the index of the current edge relative to the accept edge.
        for (int j = 0; j < IN_SIZE; j++)
          if (int'(skew_q[j*SKEW_W +: SKEW_W]) == int'(cnt_q) + 1) dut_in_d[j] = target_q[j];
        if (int'(cnt_q) + 1 >= SKEW_MAX) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (int'(cnt_q) >= DUT_LATENCY - 1) begin
          m_out_d     = dut_out;
          m_applied_d = dut_in_q;
          m_valid_d   = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      skew_q      <= '0;
      dut_in_q    <= '0;
      m_valid_q   <= 1'b0;
      m_out_q     <= '0;
      m_applied_q <= '0;
`ifndef FIXED_RAND_EN
      lfsr_q      <= SEED_FIX;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      skew_q      <= skew_d;
      dut_in_q    <= dut_in_d;
      m_valid_q   <= m_valid_d;
      m_out_q     <= m_out_d;
      m_applied_q <= m_applied_d;
`ifndef FIXED_RAND_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign dut_in    = dut_in_q;
  assign m_valid   = m_valid_q;
  assign m_out     = m_out_q;
  assign m_applied = m_applied_q;

endmodule

// File: tb/tb_masked_stim_sequencer.sv
// Testbench for masked_stim_sequencer (default build, LFSR randomness).
// A second instance with SKEW_MAX=5 exercises skew fields above the maximum.
module tb_masked_stim_sequencer;

  localparam int SMAX = 3;
  localparam int LAT  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [1:0] s_secret;
  logic [7:0] s_skew;
  logic [3:0] dut_in, m_applied;
  logic       dut_out, m_out;

  logic        s_valid2, s_ready2, m_valid2, m_ready2;
  logic [1:0]  s_secret2;
  logic [11:0] s_skew2;
  logic [3:0]  dut_in2, m_applied2;
  logic        dut_out2, m_out2;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned lfsr_m;
  logic [3:0]  prev_m;

  masked_stim_sequencer #(.SKEW_MAX(SMAX), .DUT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_secret(s_secret), .s_skew(s_skew), .dut_in(dut_in), .dut_out(dut_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_out(m_out), .m_applied(m_applied)
  );

  masked_stim_sequencer #(.SKEW_MAX(5), .DUT_LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_secret(s_secret2), .s_skew(s_skew2), .dut_in(dut_in2), .dut_out(dut_out2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_out(m_out2), .m_applied(m_applied2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned v);
    return ((v % 2) == 1) ? ((v / 2) ^ 32'hB400) : (v / 2);
  endfunction

  function automatic int clampi(input int s, input int mx);
    return (s > mx) ? mx : s;
  endfunction

  // Full transaction on the main instance starting at a negedge in IDLE.
  task automatic run_txn(input logic [1:0] sec, input logic [7:0] skw, input int hold,
                         output logic [3:0] applied_o);
    logic [1:0] r;
    logic [3:0] tgt, exp;
    logic       exp_out;
    int         sk[4];
    r      = 2'(lfsr_m % 4);
    lfsr_m = lfsr_next(lfsr_m);
    tgt    = {sec[1] ^ r[1], sec[0] ^ r[0], r};
    for (int j = 0; j < 4; j++) sk[j] = clampi(int'(skw[j*2 +: 2]), SMAX);
    chk("s_ready_idle", 32'(s_ready), 32'd1);
    s_valid  = 1'b1;
    s_secret = sec;
    s_skew   = skw;
    dut_out  = 1'($urandom);
    exp_out  = dut_out;
    for (int t = 0; t <= SMAX + LAT; t++) begin
      @(negedge clk);
      s_valid  = 1'($urandom);
      s_secret = 2'($urandom);
      s_skew   = 8'($urandom);
      if (t <= SMAX) begin
        for (int j = 0; j < 4; j++) exp[j] = (t >= sk[j]) ? tgt[j] : prev_m[j];
        chk($sformatf("dut_in_t%0d", t), 32'(dut_in), 32'(exp));
      end
      chk($sformatf("m_valid_t%0d", t), 32'(m_valid), (t == SMAX + LAT) ? 32'd1 : 32'd0);
      if (t < SMAX + LAT) chk("s_ready_busy", 32'(s_ready), 32'd0);
      dut_out = 1'($urandom);
      if (t == SMAX + LAT - 1) exp_out = dut_out;
    end
    prev_m = tgt;
    chk("m_out", 32'(m_out), 32'(exp_out));
    chk("m_applied", 32'(m_applied), 32'(tgt));
    applied_o = m_applied;
    for (int h = 0; h < hold; h++) begin
      m_ready = 1'b0;
      @(negedge clk);
      s_valid = 1'($urandom);
      dut_out = ~dut_out;
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_m_out", 32'(m_out), 32'(exp_out));
      chk("hold_m_applied", 32'(m_applied), 32'(tgt));
      chk("hold_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    s_valid = 1'b1;   // present on the release edge; must not be accepted
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("release_m_valid", 32'(m_valid), 32'd0);
    chk("release_s_ready", 32'(s_ready), 32'd1);
    chk("dut_in_holds", 32'(dut_in), 32'(tgt));
  endtask

  initial begin
    logic [3:0] app;
    logic [1:0] r, sec;
    logic [3:0] tgt, exp;
    int         sk2[4];
    int unsigned l2;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_secret = '0; s_skew = '0; dut_out = 1'b0;
    s_valid2 = 1'b0; m_ready2 = 1'b0; s_secret2 = '0; s_skew2 = '0; dut_out2 = 1'b0;
    lfsr_m = 1; prev_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_out", 32'(m_out), 32'd0);
    chk("rst_m_applied", 32'(m_applied), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst2_dut_in", 32'(dut_in2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Skew fields above the maximum on the SKEW_MAX=5 instance.
    l2 = 1;
    r  = 2'(l2 % 4);
    sec = 2'b10;
    tgt = {sec[1] ^ r[1], sec[0] ^ r[0], r};
    s_skew2 = {3'd7, 3'd6, 3'd5, 3'd7};
    for (int j = 0; j < 4; j++) sk2[j] = clampi(int'(s_skew2[j*3 +: 3]), 5);
    s_secret2 = sec; dut_out2 = 1'b1; s_valid2 = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      s_valid2 = 1'b0;
      if (t <= 5) begin
        for (int j = 0; j < 4; j++) exp[j] = (t >= sk2[j]) ? tgt[j] : 1'b0;
        chk($sformatf("clamp_dut_in_t%0d", t), 32'(dut_in2), 32'(exp));
      end
      chk($sformatf("clamp_m_valid_t%0d", t), 32'(m_valid2), (t == 6) ? 32'd1 : 32'd0);
    end
    chk("clamp_m_applied", 32'(m_applied2), 32'(tgt));
    chk("clamp_m_out", 32'(m_out2), 32'd1);
    m_ready2 = 1'b1;
    @(negedge clk);
    m_ready2 = 1'b0;
    chk("clamp_release", 32'(s_ready2), 32'd1);

    // LFSR sequence from the seed with zero secrets: rand 01, 00, 00.
    run_txn(2'b00, 8'($urandom), 0, app);
    chk("lfsr_txn1", 32'(app), 32'h5);
    run_txn(2'b00, 8'($urandom), 0, app);
    chk("lfsr_txn2", 32'(app), 32'h0);
    run_txn(2'b00, 8'($urandom), 0, app);
    chk("lfsr_txn3", 32'(app), 32'h0);

    // Staircase skew {3,2,1,0}, then backpressure for 5 cycles.
    run_txn(2'($urandom), {2'd3, 2'd2, 2'd1, 2'd0}, 1, app);
    run_txn(2'($urandom), 8'($urandom), 5, app);

    for (int n = 0; n < 20; n++)
      run_txn(2'($urandom), 8'($urandom), int'($urandom_range(0, 3)), app);

    // Reset two cycles after the accept edge drops the transaction.
    r   = 2'(lfsr_m % 4);
    sec = 2'($urandom);
    tgt = {sec[1] ^ r[1], sec[0] ^ r[0], r};
    s_valid = 1'b1; s_secret = sec; s_skew = '0;
    @(negedge clk);
    s_valid = 1'b0;
    chk("pre_rst_dut_in", 32'(dut_in), 32'(tgt));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_dut_in", 32'(dut_in), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    lfsr_m = 1; prev_m = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < SMAX + LAT + 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_capture", 32'(m_valid), 32'd0);
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    end

    // LFSR restarts from the seed.
    run_txn(2'b00, 8'($urandom), 0, app);
    chk("seed_restart", 32'(app), 32'h5);
    for (int n = 0; n < 4; n++)
      run_txn(2'($urandom), 8'($urandom), int'($urandom_range(0, 2)), app);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_stim_sequencer.md
Name: masked_stim_sequencer

Overview:
Parametrised successor to the fixed 4-bit share/random DUT interface used in the correlation flow. Accepts unmasked secret vectors over a valid/ready handshake and masks them with fresh randomness. Launches the resulting input bus into a gate-level DUT with per-bit programmable cycle skew, waits a fixed DUT latency, then captures the DUT output. Returns the capture together with the applied vector for trace alignment.

Parameters:
N_SECRETS, 2, number of secret bits, each masked into one share bit
N_RAND, 2, number of random bits driven to the DUT; 1..LFSR_W
OUT_SIZE, 1, DUT output width
DUT_LATENCY, 1, cycles from last launch edge to capture edge; must be >=1
SKEW_MAX, 3, maximum per-bit launch skew in cycles
LFSR_W, 16, internal LFSR width; fixed Galois polynomial 0xB400 at 16
LFSR_SEED, 16'h0001, LFSR reset value; 0 is replaced by 1
(derived) IN_SIZE = N_SECRETS+N_RAND; SKEW_W = $clog2(SKEW_MAX+1), minimum 1

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
s_valid  in  1  request valid
s_ready  out  1  request ready; high only in IDLE
s_secret  in  N_SECRETS  unmasked secret bits
s_skew  in  IN_SIZE*SKEW_W  per-bit launch skew; field j = bits [j*SKEW_W +: SKEW_W]
dut_in  out  IN_SIZE  DUT input bus = {masked[N_SECRETS-1:0], rand[N_RAND-1:0]}; registered
dut_out  in  OUT_SIZE  DUT output
m_valid  out  1  capture valid
m_ready  in  1  capture accepted
m_out  out  OUT_SIZE  captured dut_out
m_applied  out  IN_SIZE  final dut_in vector of this transaction

Behaviour:
- Reset values (asynchronous assert): state IDLE, dut_in 0, m_valid 0, m_out 0, m_applied 0, lfsr LFSR_SEED (0 becomes 1), skew counter 0, latched config 0. After reset s_ready=1 (decoded from IDLE).
- FSM states: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
- Accept edge E0: at a rising edge in IDLE with s_valid=1.
  - Latch s_secret and s_skew. Skew fields > SKEW_MAX are clamped to SKEW_MAX.
  - rand = lfsr[N_RAND-1:0]; then advance lfsr one step (Galois, shift right, XOR poly when shifted-out bit = 1).
  - masked[i] = secret[i] ^ rand[i % N_RAND].
  - Go to LAUNCH, counter k=0.
- Launch: bit j of dut_in takes its new value at edge E0+skew[j]. Until then it holds the previous transaction's value.
  - Skew 0 bits update at E0 itself.
  - LAUNCH ends at edge E_SKEW_MAX; all bits have then updated. Go to WAIT.
  - Always SKEW_MAX+1 edges regardless of the configured skews.
- WAIT: lasts DUT_LATENCY edges. At edge E_(SKEW_MAX+DUT_LATENCY):
  - m_out <= dut_out; m_applied <= dut_in; m_valid <= 1; go to DONE.
- DONE: m_valid, m_out and m_applied are held stable while m_ready=0.
  - An edge with m_ready=1 clears m_valid and returns to IDLE.
  - s_ready rises the cycle after that edge; there is no same-cycle re-accept.
- dut_in holds its last value between transactions; it is not returned to 0.
- s_valid outside IDLE is ignored: no latch, no lfsr step.
- Minimum transaction period: SKEW_MAX+DUT_LATENCY+2 cycles.
- Reset mid-operation: the transaction is dropped with no m_valid pulse, and all state returns to reset values. The LFSR restarts from the seed.
- No combinational path from any input to any output except s_ready, which depends on state only.

Optional Feature:
FIXED_RAND_EN
- Defined: adds input port rand_fixed [N_RAND-1:0]. rand is taken from rand_fixed at accept; the LFSR and its step are removed. Used for deterministic correlation reference runs.
- Undefined: no rand_fixed port; randomness comes from the LFSR as above.

Test Plan:
- FIXED_RAND_EN, rand_fixed=2'b10, s_secret=2'b11, all skew 0, SKEW_MAX=3, DUT_LATENCY=1 -> dut_in=4'b0110 after E0; m_valid rises after E4; m_applied=4'b0110.
- Skew fields {bit3..bit0}={3,2,1,0}, previous dut_in=0, target 4'b1111 -> dut_in reads 0001, 0011, 0111, 1111 after E0, E1, E2, E3 respectively.
- LFSR, seed 16'h0001, three back-to-back transactions with secret 2'b00 -> rand sequence 2'b01, 2'b00, 2'b00; lfsr after them = 16'h2D00.
- Backpressure: m_ready held 0 for 5 cycles in DONE, dut_out toggling -> m_valid, m_out and m_applied constant; s_ready=0; s_valid pulses ignored (lfsr unchanged).
- rst asserted 2 cycles after E0 -> immediately dut_in=0, m_valid=0, state IDLE; s_ready=1 after release; no capture is ever presented.
- s_skew field = 7 with SKEW_MAX=3 (SKEW_W=2 forces a wider test build, SKEW_MAX=5, field=7) -> the bit updates at E_SKEW_MAX, same as the clamp value.
